fifo_rd_gray_ctrl: RTL and testbench

//  Read-side pointer/flag controller of the dual-clock (CDC) FIFO, clocked entirely in the read domain.

---
 rtl/fifo_gray_pkg.sv | 25 ++
 rtl/fifo_gray_cnt.sv | 39 +++
 rtl/fifo_rd_gray_ctrl.sv | 77 +++++++
 tb/tb_fifo_rd_gray_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/fifo_gray_pkg.sv
// Shared Gray-code helpers for the dual-clock FIFO pointer controllers (read and write side).
package fifo_gray_pkg;

    localparam int GRAY_MAX_W = 32;

    // Pointer width carries one extra wrap bit above the RAM address width.
    function automatic int ptr_width(input int addr_bits);
        return addr_bits + 1;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Zero-extended narrow codes convert correctly because the upper bits stay 0.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_gray_cnt.sv
// Registered binary + Gray pointer counter with enable and asynchronous active-high reset.
module fifo_gray_cnt
    import fifo_gray_pkg::*;
#(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] bin,
    output logic [W-1:0] gray
);

    logic [W-1:0] bin_r;
    logic [W-1:0] gray_r;
    logic [W-1:0] bin_next_s;
    logic [W-1:0] gray_next_s;

    assign bin_next_s  = bin_r + {{(W-1){1'b0}}, 1'b1};
    assign gray_next_s = W'(bin2gray(GRAY_MAX_W'(bin_next_s)));

    // Both codes advance together so the Gray value always mirrors the binary count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_r  <= {W{1'b0}};
            gray_r <= {W{1'b0}};
        end else if (en) begin
            bin_r  <= bin_next_s;
            gray_r <= gray_next_s;
        end else begin
            bin_r  <= bin_r;
            gray_r <= gray_r;
        end
    end

    assign bin  = bin_r;
    assign gray = gray_r;

endmodule

// File: rtl/fifo_rd_gray_ctrl.sv
// Read-side pointer/flag controller of the dual-clock FIFO, clocked only by rd_clk.
// Optional FIFO_RD_LEVEL_EN adds o_rd_level (entries in RAM, excluding the output register).
module fifo_rd_gray_ctrl
    import fifo_gray_pkg::*;
#(
    parameter int INT_FIFO_PTR_BITS_CNT = 10
) (
    input  logic                             rd_clk,
    input  logic                             rd_rst,
    input  logic                             i_dready,
    input  logic [INT_FIFO_PTR_BITS_CNT:0]   i_wr_grayptr,
    output logic                             rd_en,
    output logic                             o_valid,
    output logic [INT_FIFO_PTR_BITS_CNT-1:0] o_rd_intptr,
    output logic [INT_FIFO_PTR_BITS_CNT:0]   o_rd_grayptr
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [INT_FIFO_PTR_BITS_CNT:0]   o_rd_level
`endif
);

    localparam int N  = INT_FIFO_PTR_BITS_CNT;
    localparam int PW = ptr_width(N);

    logic [PW-1:0] rd_bin_s;
    logic [PW-1:0] rd_gray_s;
    logic          empty_s;
    logic          rd_en_s;
    logic          valid_r;

    fifo_gray_cnt #(.W(PW)) u_rd_cnt (
        .clk  (rd_clk),
        .rst  (rd_rst),
        .en   (rd_en_s),
        .bin  (rd_bin_s),
        .gray (rd_gray_s)
    );

    // Full-width compare including the wrap bit.
    assign empty_s = (rd_gray_s == i_wr_grayptr);

    // Load the output register when it is free or being drained this cycle.
    always_comb begin
        rd_en_s = 1'b0;
        if (!empty_s && (!valid_r || i_dready)) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // Output register valid: set on load, cleared on drain, otherwise held.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            valid_r <= 1'b0;
        end else if (rd_en_s) begin
            valid_r <= 1'b1;
        end else if (i_dready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign rd_en        = rd_en_s;
    assign o_valid      = valid_r;
    assign o_rd_intptr  = rd_bin_s[N-1:0];
    assign o_rd_grayptr = rd_gray_s;

`ifdef FIFO_RD_LEVEL_EN
    assign o_rd_level = PW'(gray2bin(GRAY_MAX_W'(i_wr_grayptr))) - rd_bin_s;
`else
    logic unused_wrap_s;
    assign unused_wrap_s = rd_bin_s[N];
`endif

endmodule

// File: tb/tb_fifo_rd_gray_ctrl.sv
// Directed self-checking bench for fifo_rd_gray_ctrl with N=2 (depth 4, 3-bit pointers).
module tb_fifo_rd_gray_ctrl;

    localparam int N = 2;

    logic         rd_clk;
    logic         rd_rst;
    logic         i_dready;
    logic [N:0]   i_wr_grayptr;
    logic         rd_en;
    logic         o_valid;
    logic [N-1:0] o_rd_intptr;
    logic [N:0]   o_rd_grayptr;
`ifdef FIFO_RD_LEVEL_EN
    logic [N:0]   o_rd_level;
`endif

    int checks_cnt;
    int fail_cnt;

    // Hand-computed 3-bit Gray codes for binary 0..7.
    logic [2:0] gray_tbl [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                 3'b110, 3'b111, 3'b101, 3'b100};

    fifo_rd_gray_ctrl #(.INT_FIFO_PTR_BITS_CNT(N)) dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .i_dready     (i_dready),
        .i_wr_grayptr (i_wr_grayptr),
        .rd_en        (rd_en),
        .o_valid      (o_valid),
        .o_rd_intptr  (o_rd_intptr),
        .o_rd_grayptr (o_rd_grayptr)
`ifdef FIFO_RD_LEVEL_EN
        ,
        .o_rd_level   (o_rd_level)
`endif
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks_cnt++;
        if (obs !== exp_v) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic step();
        @(posedge rd_clk);
        #1;
    endtask

    initial begin
        logic [2:0] prev_gray;
        checks_cnt   = 0;
        fail_cnt     = 0;
        rd_rst       = 1'b1;
        i_dready     = 1'b0;
        i_wr_grayptr = 3'b000;
        #2;
        check_eq("rst_valid", 32'(o_valid), 32'd0);
        check_eq("rst_rden", 32'(rd_en), 32'd0);
        check_eq("rst_gray", 32'(o_rd_grayptr), 32'd0);
        step();
        step();
        rd_rst = 1'b0;

        // Empty FIFO with ready held high: never reads.
        i_dready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq("empty_rden", 32'(rd_en), 32'd0);
            step();
        end
        check_eq("empty_addr", 32'(o_rd_intptr), 32'd0);
        check_eq("empty_gray", 32'(o_rd_grayptr), 32'd0);

        // Single word, downstream stalled.
        i_wr_grayptr = 3'b001;
        i_dready     = 1'b0;
        #1;
        check_eq("one_rden", 32'(rd_en), 32'd1);
        check_eq("one_addr", 32'(o_rd_intptr), 32'd0);
        step();
        check_eq("one_valid", 32'(o_valid), 32'd1);
        check_eq("one_gray", 32'(o_rd_grayptr), 32'b001);
        check_eq("one_addr1", 32'(o_rd_intptr), 32'd1);
        check_eq("one_rden0", 32'(rd_en), 32'd0);
        step();
        check_eq("stall_valid", 32'(o_valid), 32'd1);
        check_eq("stall_gray", 32'(o_rd_grayptr), 32'b001);
        i_dready = 1'b1;
        #1;
        check_eq("drain_rden", 32'(rd_en), 32'd0);
        step();
        check_eq("drain_valid", 32'(o_valid), 32'd0);

        // Asynchronous reset mid-cycle, checked before any clock edge.
        @(negedge rd_clk);
        #1;
        rd_rst = 1'b1;
        #1;
        check_eq("arst_gray", 32'(o_rd_grayptr), 32'd0);
        check_eq("arst_addr", 32'(o_rd_intptr), 32'd0);
        check_eq("arst_valid", 32'(o_valid), 32'd0);
        i_wr_grayptr = 3'b000;
        step();
        rd_rst = 1'b0;

        // Four words back to back.
        i_wr_grayptr = 3'b110;
        i_dready     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("burst_rden", 32'(rd_en), 32'd1);
            check_eq("burst_addr", 32'(o_rd_intptr), 32'(k));
            check_eq("burst_valid_pre", 32'(o_valid), (k > 0) ? 32'd1 : 32'd0);
            step();
            check_eq("burst_gray", 32'(o_rd_grayptr), 32'(gray_tbl[k+1]));
        end
        check_eq("burst_end_rden", 32'(rd_en), 32'd0);
        check_eq("burst_end_valid", 32'(o_valid), 32'd1);
        step();
        check_eq("burst_valid_off", 32'(o_valid), 32'd0);

        // Four more words with the writer advancing each cycle: pointer wraps 7 -> 0.
        prev_gray = o_rd_grayptr;
        for (int k = 0; k < 4; k++) begin
            i_wr_grayptr = gray_tbl[(5 + k) % 8];
            #1;
            check_eq("wrap_rden", 32'(rd_en), 32'd1);
            check_eq("wrap_addr", 32'(o_rd_intptr), 32'(k));
            step();
            check_eq("wrap_gray", 32'(o_rd_grayptr), 32'(gray_tbl[(5 + k) % 8]));
            check_eq("wrap_onebit", 32'($countones(prev_gray ^ o_rd_grayptr)), 32'd1);
            prev_gray = o_rd_grayptr;
        end
        check_eq("wrap_end_rden", 32'(rd_en), 32'd0);
        check_eq("wrap_end_addr", 32'(o_rd_intptr), 32'd0);

`ifdef FIFO_RD_LEVEL_EN
        rd_rst   = 1'b1;
        i_dready = 1'b0;
        #1;
        rd_rst       = 1'b0;
        i_wr_grayptr = 3'b110;
        #1;
        check_eq("level_full", 32'(o_rd_level), 32'd4);
        step();
        check_eq("level_after", 32'(o_rd_level), 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
